osd_io_sequencer: RTL and testbench

Converts a host-side command word stream (valid/ready, with end-of-transaction marker) into the framed, strobed OSD I/O bus that the OSD overlay consumes on `clk_sys`: `io_osd` frames a transaction, `io_strobe` delivers each 16-bit word on its rising edge, and `io_din` carries the word. The block sits directly upstream of the OSD overlay. It enforces setup time, strobe pulse widths and inter-transaction gaps. It aborts transactions that stall mid-frame, so the overlay never sees a stuck frame.

---
 rtl/osd_io_sequencer_if.sv | 15 +
 rtl/osd_io_sequencer.sv | 166 ++++++++++++++++
 tb/tb_osd_io_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/osd_io_sequencer_if.sv
// Host command stream into the OSD I/O sequencer.
//   cmd_valid : host word valid
//   cmd_ready : sequencer accepts the word this cycle
//   cmd_data  : 16-bit command or data word
//   cmd_last  : word ends the transaction
// master = host side, slave = sequencer side.
interface osd_io_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_data;
  logic        cmd_last;

  modport master (output cmd_valid, output cmd_data, output cmd_last, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_data, input cmd_last, output cmd_ready);
endinterface

// File: rtl/osd_io_sequencer.sv
// Converts a valid/ready command word stream into the framed, strobed OSD
// I/O bus: io_osd frames a transaction, io_strobe delivers each word on its
// rising edge, io_din carries the word. Enforces setup, strobe widths, the
// inter-frame gap, and aborts frames that stall in WAIT.
// Ports:
//   clk_sys, reset_n  : clock, asynchronous active-low reset
//   cmd (slave)       : host command stream (valid/ready/data/last)
//   io_osd, io_strobe, io_din : registered OSD bus
//   busy              : sequencer not idle
//   aborted           : last transaction ended by timeout (sticky)
//   words_sent        : strobes in current/most recent frame, saturating
module osd_io_sequencer #(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned STROBE_HIGH  = 2,
  parameter int unsigned STROBE_LOW   = 2,
  parameter int unsigned GAP_CYCLES   = 4,
  parameter int unsigned TIMEOUT      = 1023
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  osd_io_sequencer_if.slave       cmd,
  output logic                    io_osd,
  output logic                    io_strobe,
  output logic [15:0]             io_din,
  output logic                    busy,
  output logic                    aborted,
  output logic [12:0]             words_sent
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 1024) begin : g_bad_setup
    $error("SETUP_CYCLES out of range");
  end
  if (STROBE_HIGH < 1 || STROBE_HIGH > 1024) begin : g_bad_high
    $error("STROBE_HIGH out of range");
  end
  if (STROBE_LOW < 1 || STROBE_LOW > 1024) begin : g_bad_low
    $error("STROBE_LOW out of range");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 1024) begin : g_bad_gap
    $error("GAP_CYCLES out of range");
  end
  if (TIMEOUT > 1023) begin : g_bad_timeout
    $error("TIMEOUT out of range");
  end

  // Phase counter compares against "last cycle of the phase".
  localparam logic [9:0] SETUP_LAST = 10'(SETUP_CYCLES - 1);
  localparam logic [9:0] HIGH_LAST  = 10'(STROBE_HIGH - 1);
  localparam logic [9:0] LOW_LAST   = 10'(STROBE_LOW - 1);
  localparam logic [9:0] GAP_LAST   = 10'(GAP_CYCLES - 1);
  localparam logic [9:0] TO_LAST    = 10'((TIMEOUT != 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW, S_WAIT, S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        last_q;
  logic [15:0] din_q;
  logic [12:0] words_q;
  logic        aborted_q;
  logic        osd_q, osd_d;
  logic        strobe_q, strobe_d;
  logic        accept, timeout;

  // State register and datapath.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      din_q     <= '0;
      words_q   <= '0;
      aborted_q <= 1'b0;
      osd_q     <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      osd_q    <= osd_d;
      strobe_q <= strobe_d;
      if (accept) begin
        din_q  <= cmd.cmd_data;
        last_q <= cmd.cmd_last;
      end
      // First word of a frame restarts the statistics.
      if (accept && state_q == S_IDLE) begin
        words_q   <= '0;
        aborted_q <= 1'b0;
      end
      if (state_q == S_HIGH && state_d == S_LOW && words_q != '1) begin
        words_q <= words_q + 13'd1;
      end
      if (timeout) begin
        aborted_q <= 1'b1;
      end
    end
  end

  // Next state; the counter reloads to zero on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 10'd1;
    accept  = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (cmd.cmd_valid) begin
          accept  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: if (cnt_q == SETUP_LAST) begin
        state_d = S_HIGH;
        cnt_d   = '0;
      end
      S_HIGH: if (cnt_q == HIGH_LAST) begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
      S_LOW: if (cnt_q == LOW_LAST) begin
        state_d = last_q ? S_GAP : S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // An accept on the final waiting cycle takes priority over the abort.
        if (cmd.cmd_valid) begin
          accept  = 1'b1;
          state_d = S_SETUP;
          cnt_d   = '0;
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          timeout = 1'b1;
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: if (cnt_q == GAP_LAST) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: handshake decoded from the current state, bus lines decoded
  // from the next state so they are registered alongside it.
  always_comb begin
    cmd.cmd_ready = (state_q == S_IDLE) || (state_q == S_WAIT);
    osd_d         = (state_d == S_SETUP) || (state_d == S_HIGH) ||
                    (state_d == S_LOW)   || (state_d == S_WAIT);
    strobe_d      = (state_d == S_HIGH);
  end

  assign io_osd     = osd_q;
  assign io_strobe  = strobe_q;
  assign io_din     = din_q;
  assign busy       = (state_q != S_IDLE);
  assign aborted    = aborted_q;
  assign words_sent = words_q;

endmodule

// File: tb/tb_osd_io_sequencer.sv
module tb_osd_io_sequencer;
  localparam int S   = 2;
  localparam int H   = 2;
  localparam int L   = 2;
  localparam int GAP = 4;
  localparam int TO  = 1023;
  localparam int W   = S + H + L;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        io_osd, io_strobe, busy, aborted;
  logic [15:0] io_din;
  logic [12:0] words_sent;
  logic        io_osd0, io_strobe0, busy0, aborted0;
  logic [15:0] io_din0;
  logic [12:0] words_sent0;

  osd_io_sequencer_if h();
  osd_io_sequencer_if h0();

  osd_io_sequencer #(
    .SETUP_CYCLES(S), .STROBE_HIGH(H), .STROBE_LOW(L),
    .GAP_CYCLES(GAP), .TIMEOUT(TO)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .cmd(h),
    .io_osd(io_osd), .io_strobe(io_strobe), .io_din(io_din),
    .busy(busy), .aborted(aborted), .words_sent(words_sent)
  );

  osd_io_sequencer #(
    .SETUP_CYCLES(1), .STROBE_HIGH(1), .STROBE_LOW(1),
    .GAP_CYCLES(1), .TIMEOUT(0)
  ) dut0 (
    .clk_sys(clk_sys), .reset_n(reset_n), .cmd(h0),
    .io_osd(io_osd0), .io_strobe(io_strobe0), .io_din(io_din0),
    .busy(busy0), .aborted(aborted0), .words_sent(words_sent0)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: timeline anchored on the edge of the most recent accept.
  int          m_active, m_a, m_last, m_done;
  logic [15:0] m_din;
  int e_ready, e_osd, e_str, e_busy, e_ab, e_words, e_idle;
  int d, e, g, n;

  task automatic expect_now(input int now);
    e_ready = 1; e_osd = 0; e_str = 0; e_busy = 0; e_ab = 0; e_words = 0; e_idle = 1;
    if (m_active != 0) begin
      d = now - m_a;
      e_busy = 1; e_idle = 0; e_words = m_done;
      if (d < W) begin
        e_ready = 0; e_osd = 1;
        e_str = (d >= S && d < S + H) ? 1 : 0;
        if (d >= S + H) e_words = m_done + 1;
      end else begin
        e_words = m_done + 1;
        e = d - W;
        if (m_last == 0 && (TO == 0 || e < TO)) begin
          e_ready = 1; e_osd = 1;
        end else begin
          g = (m_last != 0) ? e : e - TO;
          e_ab = (m_last == 0) ? 1 : 0;
          if (g < GAP) e_ready = 0;
          else begin e_ready = 1; e_busy = 0; e_idle = 1; end
        end
      end
      if (e_words > 8191) e_words = 8191;
    end
  endtask

  task automatic check_all();
    chk("cmd_ready",  32'(h.cmd_ready),  32'(e_ready));
    chk("io_osd",     32'(io_osd),       32'(e_osd));
    chk("io_strobe",  32'(io_strobe),    32'(e_str));
    chk("io_din",     32'(io_din),       32'(m_din));
    chk("busy",       32'(busy),         32'(e_busy));
    chk("aborted",    32'(aborted),      32'(e_ab));
    chk("words_sent", 32'(words_sent),   32'(e_words));
  endtask

  int acc_next, acc_first, pend, present_at, force_first, rst_done, r, a0;

  initial begin
    reset_n = 1'b0;
    h.cmd_valid = 1'b0;  h.cmd_data = '0;  h.cmd_last = 1'b0;
    h0.cmd_valid = 1'b0; h0.cmd_data = '0; h0.cmd_last = 1'b0;
    m_active = 0; m_a = 0; m_last = 0; m_done = 0; m_din = '0;
    acc_next = 0; acc_first = 0; pend = 0; rst_done = 0;
    #12;
    expect_now(0);
    check_all();
    chk("rst_ready0", 32'(h0.cmd_ready), 32'd1);
    chk("rst_osd0",   32'(io_osd0),      32'd0);
    #10 reset_n = 1'b1;
    present_at = 0;
    force_first = 1;

    while (cyc < 60000) begin
      @(posedge clk_sys); #1;
      n = cyc;
      if (acc_next != 0) begin
        m_done   = (acc_first != 0) ? 0 : m_done + 1;
        m_a      = n;
        m_last   = int'(h.cmd_last);
        m_din    = h.cmd_data;
        m_active = 1;
        acc_next = 0; pend = 0;
        h.cmd_valid = 1'b0;
        r = $urandom_range(0, 99);
        if (r < 30) present_at = n;
        else if (r < 88 || m_last != 0) present_at = n + $urandom_range(1, 20);
        else if (r < 94) present_at = n + W + TO - 1;
        else present_at = n + W + TO + $urandom_range(0, GAP + 3);
      end
      expect_now(n);
      check_all();

      if (e_str != 0 && rst_done == 0 && n > 3000) begin
        rst_done = 1;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_osd",    32'(io_osd),      32'd0);
        chk("arst_strobe", 32'(io_strobe),   32'd0);
        chk("arst_din",    32'(io_din),      32'd0);
        chk("arst_busy",   32'(busy),        32'd0);
        chk("arst_abort",  32'(aborted),     32'd0);
        chk("arst_words",  32'(words_sent),  32'd0);
        chk("arst_ready",  32'(h.cmd_ready), 32'd1);
        h.cmd_valid = 1'b0;
        pend = 0; acc_next = 0;
        m_active = 0; m_done = 0; m_din = '0;
        @(posedge clk_sys); @(posedge clk_sys); #1;
        reset_n = 1'b1;
        present_at = cyc + 2;
        force_first = 1;
        continue;
      end

      if (pend == 0 && n >= present_at) begin
        pend = 1;
        h.cmd_valid = 1'b1;
        if (force_first != 0) begin
          h.cmd_data = 16'h0041; h.cmd_last = 1'b1; force_first = 0;
        end else begin
          h.cmd_data = 16'($urandom_range(0, 65535));
          h.cmd_last = ($urandom_range(0, 7) == 0);
        end
      end
      acc_next  = (e_ready != 0 && pend != 0) ? 1 : 0;
      acc_first = e_idle;
    end

    // Timeout disabled, minimum timing parameters.
    @(posedge clk_sys); #1;
    chk("t0_idle_ready", 32'(h0.cmd_ready), 32'd1);
    h0.cmd_valid = 1'b1; h0.cmd_data = 16'h0041; h0.cmd_last = 1'b0;
    @(posedge clk_sys); #1;
    h0.cmd_valid = 1'b0;
    chk("t0_osd_up", 32'(io_osd0), 32'd1);
    chk("t0_din",    32'(io_din0), 32'h0041);
    repeat (5000) @(posedge clk_sys);
    #1;
    chk("t0_osd_hold", 32'(io_osd0),     32'd1);
    chk("t0_no_abort", 32'(aborted0),    32'd0);
    chk("t0_ready",    32'(h0.cmd_ready), 32'd1);
    chk("t0_busy",     32'(busy0),       32'd1);
    chk("t0_words",    32'(words_sent0), 32'd1);
    h0.cmd_valid = 1'b1; h0.cmd_data = 16'h0042; h0.cmd_last = 1'b1;
    @(posedge clk_sys); #1;
    a0 = cyc;
    h0.cmd_valid = 1'b0;
    chk("t0_din2",    32'(io_din0),      32'h0042);
    chk("t0_str_a",   32'(io_strobe0),   32'd0);
    chk("t0_rdy_a",   32'(h0.cmd_ready), 32'd0);
    @(posedge clk_sys); #1;
    chk("t0_str_a1",  32'(io_strobe0),   32'd1);
    @(posedge clk_sys); #1;
    chk("t0_str_a2",  32'(io_strobe0),   32'd0);
    chk("t0_words2",  32'(words_sent0),  32'd2);
    chk("t0_osd_a2",  32'(io_osd0),      32'd1);
    @(posedge clk_sys); #1;
    chk("t0_osd_gap", 32'(io_osd0),      32'd0);
    chk("t0_rdy_gap", 32'(h0.cmd_ready), 32'd0);
    chk("t0_busy_gap",32'(busy0),        32'd1);
    @(posedge clk_sys); #1;
    chk("t0_rdy_idle",32'(h0.cmd_ready), 32'd1);
    chk("t0_busy_idle",32'(busy0),       32'd0);
    chk("t0_abort_end",32'(aborted0),    32'd0);
    chk("t0_edge_cnt", 32'(cyc - a0),    32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
